// File: rtl/comb_sweep_controller_if.sv
// ---------------------------------------------------------------------------
// comb_sweep_controller_if
// Bundles the signals between the sweep controller, the unit under test
// and the requesting host.
//   start              host -> controller sweep request
//   a, b, c            controller -> unit input vector ({a,b,c}, a is MSB)
//   x_in, y_in         unit -> controller outputs being checked
//   busy, done         sweep status / one-cycle completion pulse
//   x_cap, y_cap       per-vector captured unit outputs
//   err_count          number of mismatching vectors
//   fail_valid         at least one mismatch seen
//   first_fail         index of the first mismatching vector
//   pass               last completed sweep was clean
// The slave modport is the controller.
// The master modport is its environment, which is the host plus the unit.
// ---------------------------------------------------------------------------
interface comb_sweep_controller_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       x_in;
    logic       y_in;
    logic       busy;
    logic       done;
    logic [7:0] x_cap;
    logic [7:0] y_cap;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] first_fail;
    logic       pass;

    modport slave (
        input  start, x_in, y_in,
        output a, b, c, busy, done, x_cap, y_cap,
               err_count, fail_valid, first_fail, pass
    );

    modport master (
        output start, x_in, y_in,
        input  a, b, c, busy, done, x_cap, y_cap,
               err_count, fail_valid, first_fail, pass
    );
endinterface

// File: rtl/comb_sweep_controller.sv
// ---------------------------------------------------------------------------
// comb_sweep_controller
// Walks the 3-input/2-output combinational unit through all 8 input vectors.
// Each vector is held for HOLD_CYCLES cycles and the unit outputs are
// sampled on the last of those cycles. The samples are compared against the
// golden truth tables EXP_X/EXP_Y, and the results are reported via the
// interface.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; it overrides everything
//   bus   comb_sweep_controller_if.slave. It carries the start/busy/done
//         handshake, the unit drive/observe pins and the result registers.
// ---------------------------------------------------------------------------
module comb_sweep_controller #(
    parameter int unsigned HOLD_CYCLES = 2,      // legal range 1..15
    parameter logic [7:0]  EXP_X       = 8'hA9,  // bit v = golden x for vector v
    parameter logic [7:0]  EXP_Y       = 8'hC0   // bit v = golden y for vector v
) (
    input  logic                     clk,
    input  logic                     rst,
    comb_sweep_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The hold counter starts at 0, so the sample edge is the one where it reads HOLD_CYCLES-1.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [2:0] vec_q;
    logic [3:0] hold_q;
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] x_cap_q;
    logic [7:0] y_cap_q;
    logic [3:0] err_count_q;
    logic       fail_valid_q;
    logic [2:0] first_fail_q;
    logic       pass_q;

    logic       sample_d;
    logic       mismatch_d;
    logic [3:0] err_count_d;

    // A vector fails if either unit output differs from its golden value.
    function automatic logic vec_mismatch(input logic x, input logic y, input logic [2:0] v);
        return (x != EXP_X[v]) | (y != EXP_Y[v]);
    endfunction

    // Sample-edge detection and the error count including the current vector.
    always_comb begin
        sample_d    = 1'b0;
        mismatch_d  = 1'b0;
        err_count_d = err_count_q;
        if ((state_q == DRIVE) && (hold_q == HOLD_LAST)) begin
            sample_d   = 1'b1;
            mismatch_d = vec_mismatch(bus.x_in, bus.y_in, vec_q);
        end else begin
            sample_d   = 1'b0;
            mismatch_d = 1'b0;
        end
        if (sample_d && mismatch_d) begin
            err_count_d = err_count_q + 4'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= 3'd0;
            hold_q       <= 4'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            x_cap_q      <= 8'h00;
            y_cap_q      <= 8'h00;
            err_count_q  <= 4'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 3'd0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    abc_q  <= 3'd0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state_q      <= DRIVE;
                        vec_q        <= 3'd0;
                        hold_q       <= 4'd0;
                        busy_q       <= 1'b1;
                        x_cap_q      <= 8'h00;
                        y_cap_q      <= 8'h00;
                        err_count_q  <= 4'd0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= 3'd0;
                        pass_q       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample_d) begin
                        x_cap_q[vec_q] <= bus.x_in;
                        y_cap_q[vec_q] <= bus.y_in;
                        err_count_q    <= err_count_d;
                        if (mismatch_d && !fail_valid_q) begin
                            first_fail_q <= vec_q;
                            fail_valid_q <= 1'b1;
                        end
                        hold_q <= 4'd0;
                        if (vec_q == 3'd7) begin
                            // The verdict uses the count that already includes vector 7.
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            abc_q   <= 3'd0;
                            pass_q  <= (err_count_d == 4'd0);
                        end else begin
                            vec_q <= vec_q + 3'd1;
                            abc_q <= vec_q + 3'd1;
                        end
                    end else begin
                        hold_q <= hold_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    abc_q   <= 3'd0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    abc_q   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.a          = abc_q[2];
    assign bus.b          = abc_q[1];
    assign bus.c          = abc_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.x_cap      = x_cap_q;
    assign bus.y_cap      = y_cap_q;
    assign bus.err_count  = err_count_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;
    assign bus.pass       = pass_q;

endmodule

// File: doc/comb_sweep_controller.md
Name: comb_sweep_controller

Overview:
- Sequencer that exhaustively exercises the 3-input/2-output combinational unit (inputs a,b,c; outputs x,y) in lab builds.
- Drives all 8 input vectors in order and holds each for a programmable settle time.
- Captures x/y for every vector and checks them against golden truth tables.
- Reports a per-vector capture map, a mismatch count, the first failing vector and a pass flag through a start/done handshake.

Parameters:
- HOLD_CYCLES, 2, cycles each vector is driven before sampling; legal range 1..15.
- EXP_X, 8'hA9, golden x per vector; bit v is the expected x for vector v = {a,b,c}, a is MSB.
- EXP_Y, 8'hC0, golden y per vector, same indexing.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request, sampled only in IDLE.
- a  output  1  drive to unit input a (vector bit 2).
- b  output  1  drive to unit input b (vector bit 1).
- c  output  1  drive to unit input c (vector bit 0).
- x_in  input  1  unit output x.
- y_in  input  1  unit output y.
- busy  output  1  high while vectors are being driven.
- done  output  1  one-cycle pulse at sweep end.
- x_cap  output  8  captured x; bit v holds the sample for vector v.
- y_cap  output  8  captured y; bit v holds the sample for vector v.
- err_count  output  4  number of vectors with an x or y mismatch (0..8).
- fail_valid  output  1  at least one mismatch occurred.
- first_fail  output  3  index of the first mismatching vector; valid when fail_valid=1.
- pass  output  1  last completed sweep had err_count==0.

Behaviour:
- Reset (one clk edge with rst=1) has priority over everything, including mid-sweep.
- Reset values: state=IDLE; a=b=c=0; busy=0; done=0; x_cap=0; y_cap=0; err_count=0; fail_valid=0; first_fail=0; pass=0; vector index=0; hold counter=0.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - a,b,c=0.
  - start=1 at an edge moves to DRIVE, sets vector index=0 and hold counter=0, and clears x_cap, y_cap, err_count, fail_valid, first_fail and pass.
- DRIVE:
  - busy=1; {a,b,c}=vector index, registered, so it changes only at edges.
  - Hold counter increments each cycle.
  - At the edge ending the HOLD_CYCLES-th cycle of a vector:
    - x_cap[v]<=x_in and y_cap[v]<=y_in.
    - Mismatch = (x_in!=EXP_X[v]) | (y_in!=EXP_Y[v]). On mismatch, err_count increments by 1 per vector, even if both outputs are wrong.
    - If that is the first mismatch of the sweep, first_fail<=v and fail_valid<=1.
    - If v==7, go to DONE; else v<=v+1 and hold counter<=0.
- DONE:
  - busy=0; done=1 for exactly one cycle; a,b,c=0.
  - pass<=(final err_count==0), including the vector-7 result.
  - Next state is IDLE unconditionally.
- Latency: with start accepted at edge T, busy rises after T and done is high in the cycle following edge T+8*HOLD_CYCLES. Sweep length is 8*HOLD_CYCLES busy cycles.
- start while in DRIVE or DONE is ignored.
- If start is held high continuously, a new sweep is accepted at the first edge in IDLE, i.e. one idle cycle after DONE.
- Results (x_cap, y_cap, err_count, fail_valid, first_fail, pass) hold until the next accepted start or reset.
- Vector index wraps only by FSM control; it never exceeds 7.
- err_count needs no saturation because its maximum is 8.
- x_in/y_in are sampled only at the sample edges; values at any other time are don't-care.

Test Plan:
- Correct unit connected, HOLD_CYCLES=2, pulse start at edge T -> busy for 16 cycles, done pulse one cycle after T+16, x_cap=8'hA9, y_cap=8'hC0, err_count=0, fail_valid=0, pass=1.
- x_in tied 0, y_in correct -> x_cap=8'h00, err_count=4, fail_valid=1, first_fail=0, pass=0.
- y_in tied 1, x correct -> y_cap=8'hFF, err_count=6, first_fail=0; invert x only on vector 5 -> err_count=1, first_fail=5.
- start re-pulsed at cycles 3 and 10 of a sweep -> ignored; exactly one done pulse, same results as the first scenario.
- rst asserted while vector 3 is driven -> next cycle busy=0, a=b=c=0, x_cap=0, err_count=0, pass=0, and no done pulse follows.
- HOLD_CYCLES=1 with start held high -> done every 10 cycles (8 DRIVE, 1 DONE, 1 IDLE); {a,b,c} steps 0..7 one per cycle; results are identical each sweep.
